// File: rtl/gray_seq_gen_if.sv
// Stream and control bundle for gray_seq_gen.
// master: the generator itself; slave: the controller/consumer side.
interface gray_seq_gen_if #(
  parameter int unsigned MAX_BITS = 16
);
  localparam int unsigned NB_W = $clog2(MAX_BITS + 1);

  logic                start;
  logic                stop;
  logic [NB_W-1:0]     num_bits;
  logic                dir;
  logic                one_shot;
  logic [MAX_BITS-1:0] start_idx;
  logic                out_ready;
  logic                out_valid;
  logic [MAX_BITS-1:0] gray_out;
  logic [MAX_BITS-1:0] bin_out;
  logic                wrap;
  logic                busy;
  logic                done;

  modport master (
    input  start, stop, num_bits, dir, one_shot, start_idx, out_ready,
    output out_valid, gray_out, bin_out, wrap, busy, done
  );

  modport slave (
    output start, stop, num_bits, dir, one_shot, start_idx, out_ready,
    input  out_valid, gray_out, bin_out, wrap, busy, done
  );
endinterface

// File: rtl/gray_seq_gen.sv
// Gray-code sequence source: walks a binary index over a runtime width N
// and presents each code as Gray and binary on a valid/ready stream.
module gray_seq_gen #(
  parameter int unsigned MAX_BITS = 16
) (
  input  logic         clk,
  input  logic         rst,
  gray_seq_gen_if.master bus
);
  localparam int unsigned NB_W = $clog2(MAX_BITS + 1);
  localparam logic [MAX_BITS-1:0] ONE = MAX_BITS'(1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_e;

  state_e              state_q, state_d;
  logic [MAX_BITS-1:0] mask_q, mask_d;
  logic [MAX_BITS-1:0] bin_q, bin_d;
  logic [MAX_BITS-1:0] gray_q, gray_d;
  logic                dir_q, dir_d;
  logic                one_shot_q, one_shot_d;
  logic                valid_q, valid_d;
  logic                wrap_q, wrap_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic [NB_W-1:0]     eff_n;
  logic [MAX_BITS-1:0] start_mask;
  logic                fire;
  logic                last_code;

  // Clamp the requested width into 1..MAX_BITS and expand it to a mask.
  always_comb begin
    if (bus.num_bits == '0) begin
      eff_n = NB_W'(1);
    end else if (32'(bus.num_bits) > MAX_BITS) begin
      eff_n = NB_W'(MAX_BITS);
    end else begin
      eff_n = bus.num_bits;
    end
    start_mask = '0;
    for (int unsigned i = 0; i < MAX_BITS; i++) begin
      start_mask[i] = (i < 32'(eff_n));
    end
  end

  assign fire      = valid_q & bus.out_ready;
  assign last_code = dir_q ? (bin_q == '0) : (bin_q == mask_q);

  always_comb begin
    state_d    = state_q;
    mask_d     = mask_q;
    bin_d      = bin_q;
    dir_d      = dir_q;
    one_shot_d = one_shot_q;
    valid_d    = valid_q;
    wrap_d     = 1'b0;
    busy_d     = busy_q;
    done_d     = done_q;

    if (bus.stop) begin
      state_d = ST_IDLE;
      valid_d = 1'b0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_DONE: begin
          if (bus.start) begin
            state_d    = ST_RUN;
            mask_d     = start_mask;
            dir_d      = bus.dir;
            one_shot_d = bus.one_shot;
            bin_d      = bus.start_idx & start_mask;
            valid_d    = 1'b1;
            busy_d     = 1'b1;
            done_d     = 1'b0;
          end
        end
        ST_RUN: begin
          if (fire) begin
            if (last_code) begin
              wrap_d = 1'b1;
              if (one_shot_q) begin
                // DONE keeps the last code on the outputs.
                state_d = ST_DONE;
                valid_d = 1'b0;
                busy_d  = 1'b0;
                done_d  = 1'b1;
              end else begin
                bin_d = dir_q ? mask_q : '0;
              end
            end else begin
              bin_d = (dir_q ? (bin_q - ONE) : (bin_q + ONE)) & mask_q;
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
          valid_d = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b0;
        end
      endcase
    end

    gray_d = bin_d ^ (bin_d >> 1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      mask_q     <= ONE;
      bin_q      <= '0;
      gray_q     <= '0;
      dir_q      <= 1'b0;
      one_shot_q <= 1'b0;
      valid_q    <= 1'b0;
      wrap_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      mask_q     <= mask_d;
      bin_q      <= bin_d;
      gray_q     <= gray_d;
      dir_q      <= dir_d;
      one_shot_q <= one_shot_d;
      valid_q    <= valid_d;
      wrap_q     <= wrap_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign bus.out_valid = valid_q;
  assign bus.gray_out  = gray_q;
  assign bus.bin_out   = bin_q;
  assign bus.wrap      = wrap_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
endmodule
